edge_list_loader: RTL

EDGE_LIST_LOADER -- requirements
Module: edge_list_loader

---
 rtl/edge_list_loader.sv | 116 +++++++++++
 1 files changed

// File: rtl/edge_list_loader.sv
// Edge list loader: collects edge records into a table after a start request,
// validates node indices against the latched node count, and presents the
// finished table to the solver until it is accepted.
module edge_list_loader (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  cfg_n,
  input  logic        in_valid,
  input  logic [11:0] in_data,
  input  logic        in_last,
  output logic        in_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  out_n,
  output logic [7:0]  out_e,
  output logic [11:0] edge_tab [0:255],
  output logic        err,
  output logic        ovf
);

  typedef enum logic [1:0] {StIdle, StLoad, StPresent} state_e;

  state_e      r_state;
  logic        r_in_ready;
  logic        r_out_valid;
  logic [3:0]  r_out_n;
  logic [7:0]  r_out_e;
  logic        r_err;
  logic        r_ovf;
  logic [11:0] r_tab [0:255];

  logic        w_bad;
  logic        w_full;
  logic        w_store;
  logic [7:0]  w_e_next;

  // Classify the record on in_data against the latched node count and capacity.
  always_comb begin
    w_bad    = (in_data[3:0] >= r_out_n) || (in_data[7:4] >= r_out_n);
    w_full   = (r_out_e == 8'd255);
    w_store  = !w_bad && !w_full;
    w_e_next = w_store ? (r_out_e + 8'd1) : r_out_e;
  end

  // Control FSM with registered handshake outputs and the edge table.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= StIdle;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_n     <= 4'd0;
      r_out_e     <= 8'd0;
      r_err       <= 1'b0;
      r_ovf       <= 1'b0;
      for (int i = 0; i < 256; i++) begin
        r_tab[i] <= 12'd0;
      end
    end else begin
      unique case (r_state)
        StIdle: begin
          if (start) begin
            r_out_n    <= cfg_n;
            r_out_e    <= 8'd0;
            r_err      <= 1'b0;
            r_ovf      <= 1'b0;
            r_in_ready <= 1'b1;
            r_state    <= StLoad;
          end
        end
        StLoad: begin
          if (in_valid) begin
            // Bad index wins over full: such a record would never be stored anyway.
            if (w_bad) begin
              r_err <= 1'b1;
            end else if (w_full) begin
              r_ovf <= 1'b1;
            end else begin
              r_tab[r_out_e] <= in_data;
              r_out_e        <= w_e_next;
            end
            if (in_last) begin
              r_in_ready <= 1'b0;
              if (w_e_next != 8'd0) begin
                r_out_valid <= 1'b1;
                r_state     <= StPresent;
              end else begin
                r_state <= StIdle;
              end
            end
          end
        end
        StPresent: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= StIdle;
          end
        end
        default: begin
          r_in_ready  <= 1'b0;
          r_out_valid <= 1'b0;
          r_state     <= StIdle;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_n     = r_out_n;
  assign out_e     = r_out_e;
  assign err       = r_err;
  assign ovf       = r_ovf;
  assign edge_tab  = r_tab;

endmodule
